// File: rtl/dispatch_buffer_pkg.sv
// Shared types and default sizing for the dispatch stage.
// DECODED_PACKET is the per-slot bundle exchanged with decode and rename.
package dispatch_buffer_pkg;

    localparam int N_WAY            = 3;
    localparam int SQ_SZ            = 8;
    localparam int MAX_BR_PER_CYCLE = 2;
    localparam int SQ_IDX_W         = $clog2(SQ_SZ);

    typedef struct packed {
        logic [7:0]          tag;
        logic                illegal;
        logic                cond_branch;
        logic                uncond_branch;
        logic                wr_mem;
        logic                rd_mem;
        logic [SQ_IDX_W-1:0] sq_tail;
    } DECODED_PACKET;

endpackage

// File: rtl/dispatch_buffer_if.sv
// Decode-side and dispatch-side bundle of the dispatch buffer.
// The buffer sits on the slave side; decode/rename drive the master side.
interface dispatch_buffer_if
    import dispatch_buffer_pkg::*;
#(
    parameter int N      = N_WAY,
    parameter int D      = 2 * N_WAY,
    parameter int MAX_BR = MAX_BR_PER_CYCLE
);

    localparam int NW = $clog2(N + 1);
    localparam int CW = $clog2(D + 1);
    localparam int BW = $clog2(MAX_BR + 1);

    DECODED_PACKET [N-1:0] in_insts;
    logic [NW-1:0]         in_count;
    logic [NW-1:0]         in_accept;
    logic [CW-1:0]         buf_free;
    logic [NW-1:0]         rob_open;
    logic [NW-1:0]         rs_open;
    logic [NW-1:0]         sq_open;
    logic [BW-1:0]         br_open;
    logic [SQ_IDX_W-1:0]   sq_tail_in;
    DECODED_PACKET [N-1:0] out_insts;
    logic [NW-1:0]         num_dispatch;
    logic [NW-1:0]         num_store_dispatched;
    logic [BW-1:0]         num_branch_dispatched;
    logic                  illegal_halt;

    modport master (
        output in_insts, in_count,
        output rob_open, rs_open, sq_open, br_open, sq_tail_in,
        input  in_accept, buf_free, out_insts,
        input  num_dispatch, num_store_dispatched,
        input  num_branch_dispatched, illegal_halt
    );

    modport slave (
        input  in_insts, in_count,
        input  rob_open, rs_open, sq_open, br_open, sq_tail_in,
        output in_accept, buf_free, out_insts,
        output num_dispatch, num_store_dispatched,
        output num_branch_dispatched, illegal_halt
    );

endinterface

// File: rtl/dispatch_buffer_select.sv
// In-order dispatch selection over the oldest N buffered entries.
// Stops at the first entry blocked by resources, branches, stores or illegal.
module dispatch_buffer_select
    import dispatch_buffer_pkg::*;
#(
    parameter int N      = N_WAY,
    parameter int D      = 2 * N_WAY,
    parameter int MAX_BR = MAX_BR_PER_CYCLE,
    localparam int NW    = $clog2(N + 1),
    localparam int CW    = $clog2(D + 1),
    localparam int BW    = $clog2(MAX_BR + 1)
) (
    input  DECODED_PACKET [N-1:0] window,
    input  logic [CW-1:0]         count,
    input  logic [NW-1:0]         rob_open,
    input  logic [NW-1:0]         rs_open,
    input  logic [NW-1:0]         sq_open,
    input  logic [BW-1:0]         br_open,
    input  logic [SQ_IDX_W-1:0]   sq_tail_in,
    input  logic                  block,
    output DECODED_PACKET [N-1:0] out_insts,
    output logic [NW-1:0]         num_dispatch,
    output logic [NW-1:0]         num_store,
    output logic [BW-1:0]         num_branch,
    output logic                  head_illegal
);

    always_comb begin
        DECODED_PACKET e;
        logic          stop;
        logic          is_br;
        int            st;
        int            br;
        int            nd;
        e            = '0;
        stop         = 1'b0;
        is_br        = 1'b0;
        st           = 0;
        br           = 0;
        nd           = 0;
        out_insts    = '0;
        head_illegal = 1'b0;
        for (int i = 0; i < N; i++) begin
            e     = window[i];
            is_br = e.cond_branch | e.uncond_branch;
            if (!stop) begin
                if (i >= int'(count) || i >= int'(rob_open) ||
                    i >= int'(rs_open)) begin
                    stop = 1'b1;
                end else if (e.illegal) begin
                    stop         = 1'b1;
                    head_illegal = (i == 0);
                end else if (is_br && (br == int'(br_open) ||
                                       br == MAX_BR)) begin
                    stop = 1'b1;
                end else if (e.wr_mem && st == int'(sq_open)) begin
                    stop = 1'b1;
                end else begin
                    out_insts[i] = e;
                    // memory ops carry the SQ slot the next store would take
                    if (e.wr_mem | e.rd_mem) begin
                        out_insts[i].sq_tail =
                            SQ_IDX_W'((int'(sq_tail_in) + st) % SQ_SZ);
                    end
                    st = st + int'(e.wr_mem);
                    br = br + int'(is_br);
                    nd = nd + 1;
                end
            end
        end
        if (block) begin
            out_insts = '0;
            nd        = 0;
            st        = 0;
            br        = 0;
        end
        num_dispatch = NW'(nd);
        num_store    = NW'(st);
        num_branch   = BW'(br);
    end

endmodule

// File: rtl/dispatch_buffer.sv
// Circular buffer between decode and rename with in-order N-wide dispatch.
// Holds undispatched work and freezes behind an illegal head until squash.
module dispatch_buffer
    import dispatch_buffer_pkg::*;
#(
    parameter int N      = N_WAY,
    parameter int D      = 2 * N_WAY,
    parameter int MAX_BR = MAX_BR_PER_CYCLE
) (
    input logic         clock,
    input logic         reset,
    input logic         squash,
    dispatch_buffer_if.slave bus
);

    localparam int PW = (D > 1) ? $clog2(D) : 1;
    localparam int CW = $clog2(D + 1);
    localparam int NW = $clog2(N + 1);

    DECODED_PACKET         entries [D];
    DECODED_PACKET [N-1:0] window;
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [CW-1:0]         count;
    logic                  halt;
    logic [NW-1:0]         accept;
    logic [NW-1:0]         n_disp;
    logic                  head_illegal;
    int                    free_n;
    int                    acc;

    // operands stay below 2*D, so one subtract wraps any depth
    function automatic logic [PW-1:0] wrap(input int v);
        return PW'((v >= D) ? v - D : v);
    endfunction

    always_comb begin
        window = '0;
        for (int i = 0; i < N; i++) begin
            window[i] = entries[wrap(int'(head) + i)];
        end
    end

    always_comb begin
        free_n = D - int'(count);
        acc    = (int'(bus.in_count) < free_n) ?
                 int'(bus.in_count) : free_n;
        if (squash || !reset) acc = 0;
        accept = NW'(acc);
    end

    dispatch_buffer_select #(
        .N      (N),
        .D      (D),
        .MAX_BR (MAX_BR)
    ) u_select (
        .window       (window),
        .count        (count),
        .rob_open     (bus.rob_open),
        .rs_open      (bus.rs_open),
        .sq_open      (bus.sq_open),
        .br_open      (bus.br_open),
        .sq_tail_in   (bus.sq_tail_in),
        .block        (squash | halt | ~reset),
        .out_insts    (bus.out_insts),
        .num_dispatch (n_disp),
        .num_store    (bus.num_store_dispatched),
        .num_branch   (bus.num_branch_dispatched),
        .head_illegal (head_illegal)
    );

    assign bus.in_accept    = accept;
    assign bus.num_dispatch = n_disp;
    assign bus.buf_free     = CW'(D) - count;
    assign bus.illegal_halt = halt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            halt  <= 1'b0;
        end else if (squash) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            halt  <= 1'b0;
        end else begin
            head  <= wrap(int'(head) + int'(n_disp));
            tail  <= wrap(int'(tail) + int'(accept));
            count <= count + CW'(accept) - CW'(n_disp);
            if (head_illegal) halt <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        for (int k = 0; k < N; k++) begin
            if (k < int'(accept)) begin
                entries[wrap(int'(tail) + k)] <= bus.in_insts[k];
            end
        end
    end

endmodule
